// File: rtl/uart_cmd_regbank.sv
// UART write-command parser feeding a shadow register bank; the shadow image is
// committed to the active outputs only at frame boundaries (frame_done).
module uart_cmd_regbank #(
    parameter int NUM_REGS       = 4,
    parameter int REG_WIDTH      = 72,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VALUES = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_byte,
    input  logic                          frame_done,
    input  logic                          force_overwrite,
    output logic [NUM_REGS*REG_WIDTH-1:0] regs_o,
    output logic                          scene_changed,
    output logic                          overwrite,
    output logic                          wr_strobe,
    output logic                          busy,
    output logic [7:0]                    last_cmd,
    output logic [7:0]                    err_count
);
    localparam int PAYLOAD_BYTES = (REG_WIDTH + 7) / 8;
    localparam int PAY_W         = PAYLOAD_BYTES * 8;
    localparam int CNT_W         = $clog2(PAYLOAD_BYTES + 1);
    localparam int TO_W          = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

    state_t             state_reg, state_next;
    logic [7:0]         cmd_reg;
    logic [7:0]         chk_reg;
    logic [CNT_W-1:0]   byte_cnt_reg;
    logic [PAY_W-1:0]   asm_reg;
    logic [PAY_W-1:0]   asm_shift;
    logic [TO_W-1:0]    idle_cnt_reg;
    logic               pending_reg;
    logic               scene_changed_reg;
    logic               overwrite_reg;
    logic               wr_strobe_reg;
    logic [7:0]         last_cmd_reg;
    logic [7:0]         err_count_reg;
    logic               do_write;
    logic               do_error;
    logic               timeout;
    logic               idx_ok;
    logic               last_byte;

    generate
        if (PAY_W > 8) begin : g_shift
            assign asm_shift = {asm_reg[PAY_W-9:0], rx_byte};
        end else begin : g_noshift
            assign asm_shift = rx_byte;
        end
    endgenerate

    assign idx_ok    = 32'(cmd_reg[6:0]) < NUM_REGS;
    assign last_byte = byte_cnt_reg == CNT_W'(PAYLOAD_BYTES - 1);
    assign timeout   = (state_reg != IDLE) && !rx_valid
                       && (idle_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next = state_reg;
        do_write   = 1'b0;
        do_error   = 1'b0;
        case (state_reg)
            IDLE:    if (rx_valid && rx_byte[7]) state_next = PAYLOAD;
            PAYLOAD: if (rx_valid && last_byte) state_next = CHECK;
            CHECK: begin
                if (rx_valid) begin
                    if (rx_byte == chk_reg && idx_ok) do_write = 1'b1;
                    else                              do_error = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (timeout) begin
            state_next = IDLE;
            do_error   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            cmd_reg           <= '0;
            chk_reg           <= '0;
            byte_cnt_reg      <= '0;
            asm_reg           <= '0;
            idle_cnt_reg      <= '0;
            pending_reg       <= 1'b0;
            scene_changed_reg <= 1'b0;
            overwrite_reg     <= 1'b0;
            wr_strobe_reg     <= 1'b0;
            last_cmd_reg      <= '0;
            err_count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            wr_strobe_reg <= do_write;
            if (state_reg == IDLE || rx_valid) idle_cnt_reg <= '0;
            else                               idle_cnt_reg <= idle_cnt_reg + TO_W'(1);
            if (rx_valid) begin
                case (state_reg)
                    IDLE: begin
                        if (rx_byte[7]) begin
                            cmd_reg      <= rx_byte;
                            chk_reg      <= rx_byte;
                            byte_cnt_reg <= '0;
                        end
                    end
                    PAYLOAD: begin
                        asm_reg      <= asm_shift;
                        chk_reg      <= chk_reg ^ rx_byte;
                        byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
            if (do_write) last_cmd_reg <= cmd_reg;
            if (do_error && err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
            // A write landing on the frame_done cycle misses this commit and stays pending.
            if (frame_done) begin
                scene_changed_reg <= pending_reg;
                overwrite_reg     <= pending_reg | force_overwrite;
                pending_reg       <= do_write;
            end else begin
                scene_changed_reg <= 1'b0;
                pending_reg       <= pending_reg | do_write;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [REG_WIDTH-1:0] shadow_reg;
            logic [REG_WIDTH-1:0] active_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg <= RESET_VALUES[gi*REG_WIDTH +: REG_WIDTH];
                    active_reg <= RESET_VALUES[gi*REG_WIDTH +: REG_WIDTH];
                end else begin
                    if (do_write && cmd_reg[6:0] == 7'(gi)) shadow_reg <= asm_reg[REG_WIDTH-1:0];
                    if (frame_done && pending_reg) active_reg <= shadow_reg;
                end
            end
            assign regs_o[gi*REG_WIDTH +: REG_WIDTH] = active_reg;
        end
    endgenerate

    assign scene_changed = scene_changed_reg;
    assign overwrite     = overwrite_reg;
    assign wr_strobe     = wr_strobe_reg;
    assign busy          = state_reg != IDLE;
    assign last_cmd      = last_cmd_reg;
    assign err_count     = err_count_reg;

endmodule

// File: tb/tb_uart_cmd_regbank.sv
// Scoreboard bench for uart_cmd_regbank: stimulus pushes expected events into
// queues, a negedge monitor pops them as wr_strobe / scene_changed / err_count fire.
module tb_uart_cmd_regbank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        frame_done = 1'b0;
    logic        force_overwrite = 1'b0;
    logic [63:0] regs_o;
    logic        scene_changed;
    logic        overwrite;
    logic        wr_strobe;
    logic        busy;
    logic [7:0]  last_cmd;
    logic [7:0]  err_count;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  wr_q[$];
    logic [63:0] commit_q[$];
    logic [7:0]  err_q[$];
    logic [7:0]  exp_err = 8'h00;
    logic [7:0]  prev_err = 8'h00;

    always #5 clk = ~clk;

    uart_cmd_regbank #(
        .NUM_REGS(4),
        .REG_WIDTH(16),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .frame_done(frame_done),
        .force_overwrite(force_overwrite),
        .regs_o(regs_o),
        .scene_changed(scene_changed),
        .overwrite(overwrite),
        .wr_strobe(wr_strobe),
        .busy(busy),
        .last_cmd(last_cmd),
        .err_count(err_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got a pulse, expected none", name);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    task automatic bad_cmd();
        send_cmd(8'h81, 8'h12, 8'h34, 8'hA6);
        if (exp_err != 8'hFF) begin
            exp_err++;
            err_q.push_back(exp_err);
        end
    endtask

    task automatic frame(input logic f);
        frame_done      = 1'b1;
        force_overwrite = f;
        @(posedge clk);
        #1 frame_done = 1'b0;
        force_overwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_err = err_count;
        end else begin
            if (wr_strobe) begin
                if (wr_q.size() == 0) unexpected("wr_strobe");
                else check("wr_strobe last_cmd", {56'd0, last_cmd}, {56'd0, wr_q.pop_front()});
            end
            if (scene_changed) begin
                if (commit_q.size() == 0) unexpected("scene_changed");
                else check("commit regs_o", regs_o, commit_q.pop_front());
            end
            if (err_count !== prev_err) begin
                if (err_q.size() == 0) unexpected("err_count change");
                else check("err_count", {56'd0, err_count}, {56'd0, err_q.pop_front()});
                prev_err = err_count;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset regs_o", regs_o, 64'h0);
        check("reset err_count", {56'd0, err_count}, 64'h0);
        check("reset last_cmd", {56'd0, last_cmd}, 64'h0);
        check("reset busy", {63'd0, busy}, 64'h0);
        check("reset overwrite", {63'd0, overwrite}, 64'h0);
        check("reset wr_strobe", {63'd0, wr_strobe}, 64'h0);

        // Clean write to reg1, visible only after frame_done
        wr_q.push_back(8'h81);
        send_cmd(8'h81, 8'h12, 8'h34, 8'hA7);
        check("t1 regs_o before commit", regs_o, 64'h0);
        check("t1 busy after CHK", {63'd0, busy}, 64'h0);
        commit_q.push_back(64'h0000_0000_1234_0000);
        frame(1'b0);
        check("t1 overwrite", {63'd0, overwrite}, 64'h1);

        // Bad checksum
        bad_cmd();
        frame(1'b0);
        check("t2 regs_o unchanged", regs_o, 64'h0000_0000_1234_0000);
        check("t2 overwrite", {63'd0, overwrite}, 64'h0);

        // Index out of range
        send(8'h85);
        check("t3 busy mid-command", {63'd0, busy}, 64'h1);
        send(8'hAB);
        send(8'hCD);
        exp_err++;
        err_q.push_back(exp_err);
        send(8'hE3);
        check("t3 busy after CHK", {63'd0, busy}, 64'h0);

        // Inter-byte timeout, then a clean write to reg0
        send(8'h80);
        send(8'h11);
        exp_err++;
        err_q.push_back(exp_err);
        idle(150);
        check("t4 busy after timeout", {63'd0, busy}, 64'h0);
        wr_q.push_back(8'h80);
        send_cmd(8'h80, 8'h55, 8'h66, 8'hB3);
        commit_q.push_back(64'h0000_0000_1234_5566);
        frame(1'b0);
        check("t4 overwrite", {63'd0, overwrite}, 64'h1);

        // Two writes to reg0 in one frame: last one wins
        wr_q.push_back(8'h80);
        send_cmd(8'h80, 8'h11, 8'h11, 8'h80);
        wr_q.push_back(8'h80);
        send_cmd(8'h80, 8'h22, 8'h22, 8'h80);
        commit_q.push_back(64'h0000_0000_1234_2222);
        frame(1'b0);

        // CHK on the same cycle as frame_done defers the commit by one frame
        wr_q.push_back(8'h83);
        send(8'h83);
        send(8'hBE);
        send(8'hEF);
        frame_done = 1'b1;
        send(8'hD2);
        frame_done = 1'b0;
        check("t5 regs_o held", regs_o, 64'h0000_0000_1234_2222);
        check("t5 overwrite old pending", {63'd0, overwrite}, 64'h0);
        commit_q.push_back(64'hBEEF_0000_1234_2222);
        frame(1'b0);
        check("t5 overwrite deferred", {63'd0, overwrite}, 64'h1);
        frame(1'b1);
        check("t5 overwrite forced", {63'd0, overwrite}, 64'h1);
        check("t5 regs_o after forced", regs_o, 64'hBEEF_0000_1234_2222);

        // Reset in the middle of a command
        send(8'h81);
        send(8'h12);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_err = 8'h00;
        check("t6 regs_o reset", regs_o, 64'h0);
        check("t6 err_count reset", {56'd0, err_count}, 64'h0);
        check("t6 last_cmd reset", {56'd0, last_cmd}, 64'h0);
        check("t6 busy reset", {63'd0, busy}, 64'h0);
        check("t6 overwrite reset", {63'd0, overwrite}, 64'h0);
        frame(1'b0);
        check("t6 regs_o no stale write", regs_o, 64'h0);
        wr_q.push_back(8'h82);
        send_cmd(8'h82, 8'h00, 8'hFF, 8'h7D);
        commit_q.push_back(64'h0000_00FF_0000_0000);
        frame(1'b0);
        check("t6 overwrite", {63'd0, overwrite}, 64'h1);

        // Error counter saturation
        for (int i = 0; i < 300; i++) bad_cmd();
        idle(2);
        check("t6 err_count saturated", {56'd0, err_count}, 64'hFF);

        idle(5);
        check("wr_q drained", 64'(wr_q.size()), 64'h0);
        check("commit_q drained", 64'(commit_q.size()), 64'h0);
        check("err_q drained", 64'(err_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
